seven_segment_scan: RTL and testbench
=====================================

// Module: seven_segment_scan
// PURPOSE
//   Time-multiplexed driver for DIGITS seven-segment digits sharing one segment bus.
//   - Latches a packed nibble value on load.
//   - Scans the digits at a programmable refresh rate.
//   - Optionally blanks leading zeros.
//   Sits between the frequency counter's BCD result and the display pins.
// PARAMETERS
//   DIGITS  4  number of digits scanned, >= 2; digit 0 = least significant
//   DIV_W   8  width of the refresh prescaler / refresh_div port
// PORTS
//   clk          in   1           clock
//   reset        in   1           synchronous, active-high
//   load         in   1           capture value into shadow register
//   value        in   4*DIGITS    packed nibbles; [3:0] = digit 0
//   blank_lz     in   1           1 = blank leading zero digits
//   refresh_div  in   DIV_W       digit dwell = refresh_div+1 cycles
//   segments     out  7           bit0=a .. bit6=g, active-high, registered
//   digit_en     out  DIGITS      one-hot digit select, registered
// BEHAVIOUR
//   Reset (synchronous; mid-operation reset takes effect on the next edge):
//   - value_r=0, pre=0, idx=0, segments=0, digit_en=0 (all digits off).
//   Shadow register:
//   - On load, value_r <= value at the next edge; otherwise value_r holds.
//   Prescaler:
//   - When pre >= refresh_div: tick=1 and pre <= 0; otherwise pre <= pre+1.
//   - The compare uses the live refresh_div. Lowering it mid-count therefore
//     ticks on the next cycle and never hangs.
//   - refresh_div=0 ticks every cycle.
//   Scan index:
//   - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
//   - idx width is $clog2(DIGITS); DIGITS need not be a power of 2.
//   Output register (loads every non-reset cycle):
//   - digit_en <= 1<<idx.
//   - segments <= glyph(value_r[4*idx+:4]), or 0 when that digit is blanked.
//   - Latency: 1 cycle from an idx or value_r change to the outputs.
//   - First cycle after reset release: digit_en=1, segments=glyph(0).
//   Leading-zero blanking:
//   - Digit i>0 is blanked iff blank_lz=1 and nibbles i..DIGITS-1 of value_r are all 0.
//   - Digit 0 is never blanked, so value 0 shows "0".
//   Glyphs:
//   - 0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//   - 5=1101101  6=1111101  7=0000111  8=1111111  9=1101111
//   Simultaneous load and tick:
//   - Both take effect. Outputs next show the new value_r at the new idx.
//   Outputs never glitch: both outputs are registers and change on the same edge.
// CONFIGURATION
//   Macro SEVEN_SEGMENT_SCAN_HEX_EN.
//   - Defined: nibbles 10..15 decode to hex glyphs
//     A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001.
//   - Undefined: nibbles 10..15 give segments=0 (blank).
//   - Blanking rules are unchanged either way.
// STRUCTURE
//   Package seg7_pkg:
//   - 7-bit glyph localparams SEG_0..SEG_F and SEG_BLANK.
//   - Function seg7_glyph(nibble) that honours the macro.
//   Sub-module seg7_decode:
//   - Combinational nibble -> segments using seg7_pkg.
//   - One instance, on the selected nibble.
//   Top level holds the shadow register, prescaler, idx counter, blank logic
//   and output registers.
// TESTING
//   1. Reset: hold reset 3 cycles -> segments=0, digit_en=0.
//      Release -> next cycle digit_en=4'b0001, segments=0111111.
//   2. DIGITS=4, refresh_div=0, load value=16'h1234 -> digit_en steps
//      0001,0010,0100,1000,0001 one per cycle; segments 1100110,1001111,1011011,0000110.
//   3. refresh_div=3 -> each digit_en value is held exactly 4 cycles.
//      Then write refresh_div=0 while pre=2 -> tick on the next cycle.
//   4. blank_lz=1, value=16'h0070 -> digits 2,3 show 0; digit 1=0000111; digit 0=0111111.
//      value=0 -> only digit 0 lit, showing 0111111.
//   5. value=16'h00A0, no macro -> digit 1 segments=0.
//      With SEVEN_SEGMENT_SCAN_HEX_EN -> digit 1 segments=1110111.
//   6. load coincident with tick, then reset asserted at idx=2 ->
//      - new value appears at the new idx;
//      - after reset, idx=0 and outputs=0.
//      Also run DIGITS=3 to check the 2->0 wrap.

Source files
------------

// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and nibble decode for seven_segment_scan.
// Define SEVEN_SEGMENT_SCAN_HEX_EN to decode nibbles A..F; otherwise they show blank.
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

`ifdef SEVEN_SEGMENT_SCAN_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = HEX_EN ? SEG_A : SEG_BLANK;
      4'hB: glyph = HEX_EN ? SEG_B : SEG_BLANK;
      4'hC: glyph = HEX_EN ? SEG_C : SEG_BLANK;
      4'hD: glyph = HEX_EN ? SEG_D : SEG_BLANK;
      4'hE: glyph = HEX_EN ? SEG_E : SEG_BLANK;
      4'hF: glyph = HEX_EN ? SEG_F : SEG_BLANK;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; honours SEVEN_SEGMENT_SCAN_HEX_EN via seg7_pkg.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = seg7_glyph(nibble);
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed DIGITS-digit seven-segment driver with programmable dwell and
// optional leading-zero blanking. Macro SEVEN_SEGMENT_SCAN_HEX_EN enables hex glyphs.
module seven_segment_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic [DIV_W-1:0]      refresh_div,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int              IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  generate
    if (DIGITS < 2) begin : g_bad_digits
      $error("seven_segment_scan: DIGITS must be at least 2");
    end
  endgenerate

  logic [4*DIGITS-1:0] value_r;
  logic [DIV_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                upper_zero;
  logic [DIGITS-1:1]   blank_mask;
  logic [3:0]          nibble;
  logic                blank;
  logic [6:0]          glyph;

  // Live compare: lowering refresh_div below pre ticks next cycle instead of wrapping.
  assign tick = (pre >= refresh_div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= '0;
      pre     <= '0;
      idx     <= '0;
    end else begin
      if (load) begin
        value_r <= value;
      end
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block is given a default before any
  // conditional logic, so no path leaves a variable unassigned and infers a latch.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero    = upper_zero && (value_r[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_lz && upper_zero;
    end
  end

  // Digit 0 is the default selection and is never blanked.
  always_comb begin
    nibble = value_r[3:0];
    blank  = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble = value_r[4*i +: 4];
        blank  = blank_mask[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble   (nibble),
    .segments (glyph)
  );

  // Both outputs register on the same edge so the pins never show a mixed digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments <= SEG_BLANK;
      digit_en <= '0;
    end else begin
      segments <= blank ? SEG_BLANK : glyph;
      digit_en <= DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: a 4-digit and a 3-digit instance,
// directed stimulus with hand-computed expected outputs checked by a monitor.
module tb_seven_segment_scan;

  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G1 = 7'b0000110;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111;
  localparam logic [6:0] G4 = 7'b1100110;
  localparam logic [6:0] G6 = 7'b1111101;
  localparam logic [6:0] G7 = 7'b0000111;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] BL = 7'b0000000;
`ifdef SEVEN_SEGMENT_SCAN_HEX_EN
  localparam logic [6:0] GA = 7'b1110111;
`else
  localparam logic [6:0] GA = 7'b0000000;
`endif

  logic        clk;
  logic        reset;
  logic        load;
  logic        blank_lz;
  logic [7:0]  refresh_div;
  logic [15:0] value_a;
  logic [11:0] value_b;
  logic [6:0]  segments_a;
  logic [3:0]  digit_en_a;
  logic [6:0]  segments_b;
  logic [2:0]  digit_en_b;

  seven_segment_scan #(.DIGITS(4), .DIV_W(8)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value_a),
    .blank_lz    (blank_lz),
    .refresh_div (refresh_div),
    .segments    (segments_a),
    .digit_en    (digit_en_a)
  );

  seven_segment_scan #(.DIGITS(3), .DIV_W(8)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value_b),
    .blank_lz    (blank_lz),
    .refresh_div (refresh_div),
    .segments    (segments_b),
    .digit_en    (digit_en_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         dut;
    logic [3:0] en;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [3:0] got_en, input logic [6:0] got_seg,
                       input logic [3:0] exp_en, input logic [6:0] exp_seg);
    vectors++;
    if (got_en !== exp_en || got_seg !== exp_seg) begin
      miscompares++;
      $display("FAIL %s: got digit_en=%b segments=%b, expected digit_en=%b segments=%b",
               name, got_en, got_seg, exp_en, exp_seg);
    end
  endtask

  // Monitor: outputs are registered, so each edge presents a new output word;
  // it is sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) check({e.name, "/a"}, digit_en_a, segments_a, e.en, e.seg);
        else            check({e.name, "/b"}, {1'b0, digit_en_b}, segments_b, e.en, e.seg);
      end
    end
  end

  // One rising edge; queue what each selected instance must show after it.
  task automatic step(input bit ca, input logic [3:0] ea, input logic [6:0] sa,
                      input bit cb, input logic [2:0] eb, input logic [6:0] sb,
                      input string name);
    exp_t e;
    @(posedge clk);
    if (ca) begin
      e.dut = 0; e.en = ea; e.seg = sa; e.name = name;
      exp_q.push_back(e);
    end
    if (cb) begin
      e.dut = 1; e.en = {1'b0, eb}; e.seg = sb; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic step_a(input logic [3:0] ea, input logic [6:0] sa, input string name);
    step(1'b1, ea, sa, 1'b0, 3'b000, BL, name);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; refresh_div = 8'd0;
    value_a = 16'h0000; value_b = 12'h000;

    // Reset held three cycles: everything dark.
    step(1, 4'b0000, BL, 0, 3'b000, BL, "reset0");
    step(1, 4'b0000, BL, 0, 3'b000, BL, "reset1");
    step(1, 4'b0000, BL, 1, 3'b000, BL, "reset2");
    reset = 1'b0;
    step(1, 4'b0001, G0, 1, 3'b001, G0, "release");

    // refresh_div=0: one digit per cycle; load lands while idx=1.
    load = 1'b1; value_a = 16'h1234; value_b = 12'h123;
    step(1, 4'b0010, G0, 1, 3'b010, G0, "scan_preload");
    load = 1'b0;
    step(1, 4'b0100, G2, 1, 3'b100, G1, "scan_d2");
    step(1, 4'b1000, G1, 1, 3'b001, G3, "scan_d3");
    step(1, 4'b0001, G4, 1, 3'b010, G2, "scan_d0");
    step(1, 4'b0010, G3, 1, 3'b100, G1, "scan_d1");
    step(1, 4'b0100, G2, 1, 3'b001, G3, "scan_d2b");
    step(1, 4'b1000, G1, 1, 3'b010, G2, "scan_d3b");

    // refresh_div=3: four-cycle dwell, then an early tick after lowering it at pre=2.
    refresh_div = 8'd3;
    for (int i = 0; i < 4; i++) step_a(4'b0001, G4, "dwell_d0");
    for (int i = 0; i < 4; i++) step_a(4'b0010, G3, "dwell_d1");
    step_a(4'b0100, G2, "dwell_d2_0");
    step_a(4'b0100, G2, "dwell_d2_1");
    refresh_div = 8'd0;
    step_a(4'b0100, G2, "lower_div");
    step_a(4'b1000, G1, "lower_div_tick");

    // Leading-zero blanking with 0x0070, then 0x0000.
    blank_lz = 1'b1; load = 1'b1; value_a = 16'h0070;
    step_a(4'b0001, G4, "lz_load");
    load = 1'b0;
    step_a(4'b0010, G7, "lz70_d1");
    step_a(4'b0100, BL, "lz70_d2");
    step_a(4'b1000, BL, "lz70_d3");
    step_a(4'b0001, G0, "lz70_d0");
    load = 1'b1; value_a = 16'h0000;
    step_a(4'b0010, G7, "lz0_load");
    load = 1'b0;
    step_a(4'b0100, BL, "lz0_d2");
    step_a(4'b1000, BL, "lz0_d3");
    step_a(4'b0001, G0, "lz0_d0");
    step_a(4'b0010, BL, "lz0_d1");

    // Nibble A: hex glyph only with the macro; still not a leading zero.
    load = 1'b1; value_a = 16'h00A0;
    step_a(4'b0100, BL, "hex_load");
    load = 1'b0;
    step_a(4'b1000, BL, "hex_d3");
    step_a(4'b0001, G0, "hex_d0");
    step_a(4'b0010, GA, "hex_d1");
    step_a(4'b0100, BL, "hex_d2");

    // Load coincident with a tick, then reset mid-scan at idx=2.
    blank_lz = 1'b0; refresh_div = 8'd1;
    step_a(4'b1000, G0, "nolz_d3");
    load = 1'b1; value_a = 16'h5678;
    step_a(4'b1000, G0, "load_tick");
    load = 1'b0;
    step_a(4'b0001, G8, "new_at_idx0");
    step_a(4'b0001, G8, "new_at_idx0_hold");
    step_a(4'b0010, G7, "new_d1");
    step_a(4'b0010, G7, "new_d1_hold");
    step_a(4'b0100, G6, "new_d2");
    reset = 1'b1;
    step(1, 4'b0000, BL, 1, 3'b000, BL, "midreset0");
    step_a(4'b0000, BL, "midreset1");
    reset = 1'b0;
    step(1, 4'b0001, G0, 1, 3'b001, G0, "rerelease");

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
